// File: rtl/game_pkg.sv
// Shared game definitions: game_state one-hot encodings, playfield geometry,
// collision source codes and the collision detector FSM states.
package game_pkg;

   typedef enum logic [3:0] {
      START_SCREEN = 4'b0001,
      IN_GAME      = 4'b0010,
      PAUSE        = 4'b0100,
      END_SCREEN   = 4'b1000
   } game_state_e;

   localparam int NUM_PIPES   = 4;
   localparam int PIPE_SIZE_X = 78;
   localparam int PIPE_GAP    = 128;
   localparam int BIRD_W      = 34;
   localparam int BIRD_H      = 24;
   localparam int PLAY_HEIGHT = 420;

   // Pipe hits use the pipe index 0..3 directly as the source code
   localparam logic [2:0] HIT_FLOOR = 3'd4;
   localparam logic [2:0] HIT_CEIL  = 3'd5;
   localparam logic [2:0] HIT_NONE  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK_PIPE,
      ST_CHECK_BOUNDS,
      ST_DONE
   } cd_state_e;

endpackage

// File: rtl/collision_detector_if.sv
// Bus between the movement logic / game FSM (master) and the collision
// detector (slave): frame tick, game state, coordinates in; results out.
interface collision_detector_if;

   logic               frame_tick;
   logic [3:0]         game_state;
   logic signed [31:0] birdX;
   logic signed [31:0] birdY;
   logic signed [31:0] pipeX_1;
   logic signed [31:0] pipeX_2;
   logic signed [31:0] pipeX_3;
   logic signed [31:0] pipeX_4;
   logic signed [31:0] pipeY_1;
   logic signed [31:0] pipeY_2;
   logic signed [31:0] pipeY_3;
   logic signed [31:0] pipeY_4;
   logic               collision;
   logic [2:0]         hit_src;
   logic               check_done;
   logic               overrun;

   modport master (
      output frame_tick, game_state, birdX, birdY,
             pipeX_1, pipeX_2, pipeX_3, pipeX_4,
             pipeY_1, pipeY_2, pipeY_3, pipeY_4,
      input  collision, hit_src, check_done, overrun
   );

   modport slave (
      input  frame_tick, game_state, birdX, birdY,
             pipeX_1, pipeX_2, pipeX_3, pipeX_4,
             pipeY_1, pipeY_2, pipeY_3, pipeY_4,
      output collision, hit_src, check_done, overrun
   );

endinterface

// File: rtl/pipe_hit_check.sv
// Combinational test of the bird box against one pipe column. All sums are
// widened to 33 bits so large or negative coordinates never wrap; edges that
// merely touch do not count as a hit.
module pipe_hit_check
   import game_pkg::*;
#(
   parameter int PIPE_SIZE_X = game_pkg::PIPE_SIZE_X,
   parameter int PIPE_GAP    = game_pkg::PIPE_GAP,
   parameter int BIRD_W      = game_pkg::BIRD_W,
   parameter int BIRD_H      = game_pkg::BIRD_H
) (
   input  logic signed [31:0] birdX_i,
   input  logic signed [31:0] birdY_i,
   input  logic signed [31:0] pipeX_i,
   input  logic signed [31:0] pipeY_i,
   output logic               hit_o
);

   localparam logic signed [32:0] SIZE_X = 33'(PIPE_SIZE_X);
   localparam logic signed [32:0] GAP    = 33'(PIPE_GAP);
   localparam logic signed [32:0] BW     = 33'(BIRD_W);
   localparam logic signed [32:0] BH     = 33'(BIRD_H);

   logic signed [32:0] bx, by, px, py;
   logic               horiz, vert;

   // Overlap in X with the column, and bird outside the gap in Y
   always_comb begin
      bx    = 33'(birdX_i);
      by    = 33'(birdY_i);
      px    = 33'(pipeX_i);
      py    = 33'(pipeY_i);
      horiz = (bx < px + SIZE_X) && (bx + BW > px);
      vert  = (by < py) || (by + BH > py + GAP);
      hit_o = horiz && vert;
   end

endmodule

// File: rtl/collision_detector.sv
// Frame-rate collision detector. Each frame tick (while IN_GAME and not yet
// collided) it snapshots bird/pipe coordinates, checks one pipe per clock,
// then the play-area bounds, and reports a sticky collision with its source.
// Optional build macro CEILING_KILL_EN: also treat birdY < 0 as a collision.
module collision_detector
   import game_pkg::*;
#(
   parameter int NUM_PIPES   = game_pkg::NUM_PIPES,
   parameter int PIPE_SIZE_X = game_pkg::PIPE_SIZE_X,
   parameter int PIPE_GAP    = game_pkg::PIPE_GAP,
   parameter int BIRD_W      = game_pkg::BIRD_W,
   parameter int BIRD_H      = game_pkg::BIRD_H,
   parameter int PLAY_HEIGHT = game_pkg::PLAY_HEIGHT
) (
   input logic                 clk,
   input logic                 rst,
   collision_detector_if.slave bus
);

   localparam logic signed [32:0] BH    = 33'(BIRD_H);
   localparam logic signed [32:0] FLOOR = 33'(PLAY_HEIGHT);
   localparam logic [1:0]         LAST  = 2'(NUM_PIPES - 1);

   cd_state_e          state_q;
   logic [1:0]         index_q;
   logic signed [31:0] birdXSnap_q, birdYSnap_q;
   logic signed [31:0] pipeXSnap_q [4];
   logic signed [31:0] pipeYSnap_q [4];
   logic               pendValid_q;
   logic [2:0]         pendSrc_q;
   logic               collision_q, checkDone_q, overrun_q;
   logic [2:0]         hitSrc_q;

   logic               pipeHit, floorHit, pendValid_d;
   logic [2:0]         pendSrc_d;
   logic [1:0]         index_d;
   logic               inGame;
`ifdef CEILING_KILL_EN
   logic               ceilHit;
`endif

   pipe_hit_check #(
      .PIPE_SIZE_X (PIPE_SIZE_X),
      .PIPE_GAP    (PIPE_GAP),
      .BIRD_W      (BIRD_W),
      .BIRD_H      (BIRD_H)
   ) u_pipeHit (
      .birdX_i (birdXSnap_q),
      .birdY_i (birdYSnap_q),
      .pipeX_i (pipeXSnap_q[index_q]),
      .pipeY_i (pipeYSnap_q[index_q]),
      .hit_o   (pipeHit)
   );

   // Resolve the frame's source after bounds: pipe, then floor, then ceiling
   always_comb begin
      inGame      = (bus.game_state == IN_GAME);
      index_d     = index_q + 2'd1;
      floorHit    = (33'(birdYSnap_q) + BH > FLOOR);
      pendValid_d = pendValid_q;
      pendSrc_d   = pendSrc_q;
`ifdef CEILING_KILL_EN
      ceilHit     = birdYSnap_q[31];
`endif
      if (!pendValid_q && floorHit) begin
         pendValid_d = 1'b1;
         pendSrc_d   = HIT_FLOOR;
      end
`ifdef CEILING_KILL_EN
      else if (!pendValid_q && ceilHit) begin
         pendValid_d = 1'b1;
         pendSrc_d   = HIT_CEIL;
      end
`endif
   end

   // Check sequencer; outputs are registered so the result and check_done
   // appear together in the DONE cycle, and START_SCREEN overrides everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         index_q     <= 2'd0;
         birdXSnap_q <= '0;
         birdYSnap_q <= '0;
         for (int i = 0; i < 4; i++) begin
            pipeXSnap_q[i] <= '0;
            pipeYSnap_q[i] <= '0;
         end
         pendValid_q <= 1'b0;
         pendSrc_q   <= HIT_NONE;
         collision_q <= 1'b0;
         hitSrc_q    <= HIT_NONE;
         checkDone_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         checkDone_q <= 1'b0;
         if (bus.frame_tick && state_q != ST_IDLE) begin
            overrun_q <= 1'b1;
         end
         if (bus.game_state == START_SCREEN) begin
            state_q     <= ST_IDLE;
            index_q     <= 2'd0;
            pendValid_q <= 1'b0;
            pendSrc_q   <= HIT_NONE;
            collision_q <= 1'b0;
            hitSrc_q    <= HIT_NONE;
            overrun_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (bus.frame_tick && inGame && !collision_q) begin
                     birdXSnap_q    <= bus.birdX;
                     birdYSnap_q    <= bus.birdY;
                     pipeXSnap_q[0] <= bus.pipeX_1;
                     pipeXSnap_q[1] <= bus.pipeX_2;
                     pipeXSnap_q[2] <= bus.pipeX_3;
                     pipeXSnap_q[3] <= bus.pipeX_4;
                     pipeYSnap_q[0] <= bus.pipeY_1;
                     pipeYSnap_q[1] <= bus.pipeY_2;
                     pipeYSnap_q[2] <= bus.pipeY_3;
                     pipeYSnap_q[3] <= bus.pipeY_4;
                     index_q        <= 2'd0;
                     pendValid_q    <= 1'b0;
                     pendSrc_q      <= HIT_NONE;
                     state_q        <= ST_CHECK_PIPE;
                  end
               end
               ST_CHECK_PIPE: begin
                  if (!inGame) begin
                     state_q     <= ST_IDLE;
                     pendValid_q <= 1'b0;
                  end else begin
                     if (pipeHit && !pendValid_q) begin
                        pendValid_q <= 1'b1;
                        pendSrc_q   <= {1'b0, index_q};
                     end
                     index_q <= index_d;
                     if (index_q == LAST) begin
                        state_q <= ST_CHECK_BOUNDS;
                     end
                  end
               end
               ST_CHECK_BOUNDS: begin
                  if (!inGame) begin
                     state_q     <= ST_IDLE;
                     pendValid_q <= 1'b0;
                  end else begin
                     state_q     <= ST_DONE;
                     checkDone_q <= 1'b1;
                     pendValid_q <= pendValid_d;
                     pendSrc_q   <= pendSrc_d;
                     if (pendValid_d) begin
                        collision_q <= 1'b1;
                        hitSrc_q    <= pendSrc_d;
                     end
                  end
               end
               ST_DONE: begin
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.collision  = collision_q;
   assign bus.hit_src    = hitSrc_q;
   assign bus.check_done = checkDone_q;
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: directed frames covering the
// edge cases, then random frames scored against a geometric reference model.
module tb_collision_detector;
   import game_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   int   tbPipeX [4];
   int   tbPipeY [4];
   logic mCollision;
   logic [2:0] mSrc;
   logic mOverrun;

   collision_detector_if bus ();

   collision_detector dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time limit so the bench never hangs
   initial begin
      #500000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   // Compare one observed value against the bench's expectation
   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Expected source straight from the geometry rules, in 64-bit arithmetic
   function automatic logic [2:0] modelSrc(input int bx, input int by);
      longint x, y, px, py;
      x = bx;
      y = by;
      for (int i = 0; i < 4; i++) begin
         px = tbPipeX[i];
         py = tbPipeY[i];
         if (x < px + 78 && x + 34 > px && (y < py || y + 24 > py + 128))
            return 3'(i);
      end
      if (y + 24 > 420) return 3'd4;
`ifdef CEILING_KILL_EN
      if (y < 0) return 3'd5;
`endif
      return 3'd7;
   endfunction

   // Drive bird and the current pipe table onto the bus
   task automatic applyStimulus(input int bx, input int by);
      bus.birdX   = bx;
      bus.birdY   = by;
      bus.pipeX_1 = tbPipeX[0];
      bus.pipeX_2 = tbPipeX[1];
      bus.pipeX_3 = tbPipeX[2];
      bus.pipeX_4 = tbPipeX[3];
      bus.pipeY_1 = tbPipeY[0];
      bus.pipeY_2 = tbPipeY[1];
      bus.pipeY_3 = tbPipeY[2];
      bus.pipeY_4 = tbPipeY[3];
   endtask

   task automatic farPipes();
      for (int i = 0; i < 4; i++) begin
         tbPipeX[i] = 700 + 200 * i;
         tbPipeY[i] = 150;
      end
   endtask

   // One START_SCREEN cycle, then back to IN_GAME
   task automatic clearGame();
      bus.game_state = START_SCREEN;
      @(posedge clk); #1;
      bus.game_state = IN_GAME;
      mCollision = 1'b0;
      mSrc       = HIT_NONE;
      mOverrun   = 1'b0;
   endtask

   // Issue one tick and watch 12 cycles for latency, pulse width and result
   task automatic runFrame(input string tag, input int bx, input int by);
      int       lat;
      int       doneCnt;
      logic     colAtDone;
      logic [2:0] srcAtDone;
      logic [2:0] src;
      logic     expectDone;
      applyStimulus(bx, by);
      expectDone = !mCollision;
      src        = modelSrc(bx, by);
      lat        = -1;
      doneCnt    = 0;
      colAtDone  = bus.collision;
      srcAtDone  = bus.hit_src;
      bus.frame_tick = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         bus.frame_tick = 1'b0;
         if (bus.check_done === 1'b1) begin
            doneCnt++;
            if (lat < 0) begin
               lat       = c;
               colAtDone = bus.collision;
               srcAtDone = bus.hit_src;
            end
         end
      end
      if (expectDone) begin
         if (src != HIT_NONE) begin
            mCollision = 1'b1;
            mSrc       = src;
         end
         checkOutput({tag, "_latency"}, lat, 6);
         checkOutput({tag, "_donePulses"}, doneCnt, 1);
         checkOutput({tag, "_collision"}, colAtDone, mCollision);
         checkOutput({tag, "_hitSrc"}, srcAtDone, mSrc);
      end else begin
         checkOutput({tag, "_noDone"}, doneCnt, 0);
         checkOutput({tag, "_collisionHeld"}, bus.collision, mCollision);
         checkOutput({tag, "_hitSrcHeld"}, bus.hit_src, mSrc);
      end
      checkOutput({tag, "_overrun"}, bus.overrun, mOverrun);
   endtask

   // Directed steps followed by random frames
   initial begin
      int seen;
      total = 0;
      bad   = 0;
      mCollision = 1'b0;
      mSrc       = HIT_NONE;
      mOverrun   = 1'b0;
      bus.frame_tick = 1'b0;
      bus.game_state = START_SCREEN;
      farPipes();
      applyStimulus(100, 200);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_collision", bus.collision, 0);
      checkOutput("reset_hitSrc", bus.hit_src, 7);
      checkOutput("reset_checkDone", bus.check_done, 0);
      checkOutput("reset_overrun", bus.overrun, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      bus.game_state = IN_GAME;

      $display("[TB] clear frame");
      farPipes();
      runFrame("clear", 100, 200);

      $display("[TB] pipe 2 hit, then sticky");
      tbPipeX[1] = 90;
      tbPipeY[1] = 150;
      runFrame("pipe2", 100, 100);
      runFrame("sticky", 100, 100);

      $display("[TB] horizontal edge touch vs overlap");
      clearGame();
      farPipes();
      tbPipeX[0] = 134;
      runFrame("edgeTouch", 100, 100);
      tbPipeX[0] = 133;
      runFrame("edgeOverlap", 100, 100);

      $display("[TB] pipe beats floor, floor boundary");
      clearGame();
      farPipes();
      tbPipeX[2] = 100;
      tbPipeY[2] = 0;
      runFrame("pipeOverFloor", 100, 400);
      clearGame();
      farPipes();
      runFrame("floorTouch", 100, 396);
      runFrame("floorHit", 100, 397);

      $display("[TB] overrun and pause abort");
      clearGame();
      farPipes();
      tbPipeX[0] = 90;
      applyStimulus(100, 100);
      bus.frame_tick = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      bus.game_state = PAUSE;
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.check_done === 1'b1) seen++;
      end
      mOverrun = 1'b1;
      checkOutput("pause_noDone", seen, 0);
      checkOutput("pause_collision", bus.collision, 0);
      checkOutput("pause_overrun", bus.overrun, 1);
      bus.game_state = IN_GAME;
      runFrame("afterPause", 100, 100);
      clearGame();
      checkOutput("start_collision", bus.collision, 0);
      checkOutput("start_hitSrc", bus.hit_src, 7);
      checkOutput("start_overrun", bus.overrun, 0);

      $display("[TB] ceiling");
      farPipes();
      runFrame("ceiling", 100, -5);

      $display("[TB] random frames");
      for (int n = 0; n < 40; n++) begin
         if (mCollision) clearGame();
         for (int i = 0; i < 4; i++) begin
            tbPipeX[i] = int'($urandom_range(700)) - 100;
            tbPipeY[i] = int'($urandom_range(320)) - 20;
         end
         runFrame("random", int'($urandom_range(400)) + 50,
                  int'($urandom_range(470)) - 40);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
